score_seg_display: RTL and testbench

//  Consumes the 16-bit binary score from the snake game core and drives the

---
 rtl/score_seg_display.sv | 158 +++++++++++++++
 tb/tb_score_seg_display.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - binary score to BCD via sequential double-dabble, multiplexed onto a 4-digit 7-segment display
module score_seg_display #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [15:0] bcd,
    output logic        busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state, state_n;
    logic [15:0] shift_bin, shift_bin_n;
    logic [15:0] scratch, scratch_n, scratch_adj;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [13:0] last_bin, last_bin_n;
    logic [15:0] bcd_n;
    logic        busy_n;
    logic [13:0] sat_score;

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic          lit;
    logic [3:0]    digit_nib;
    logic          digit_blank;
    logic [6:0]    seg_n;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    assign sat_score = (score > 16'd9999) ? 14'd9999 : score[13:0];
    assign dp        = 1'b1;

    // Add-3 correction applied to every BCD nibble before each shift.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_n     = state;
        shift_bin_n = shift_bin;
        scratch_n   = scratch;
        bit_cnt_n   = bit_cnt;
        last_bin_n  = last_bin;
        bcd_n       = bcd;
        busy_n      = busy;
        case (state)
            IDLE: begin
                if (sat_score != last_bin) begin
                    shift_bin_n = {2'b00, sat_score};
                    last_bin_n  = sat_score;
                    scratch_n   = 16'h0000;
                    bit_cnt_n   = 4'd0;
                    busy_n      = 1'b1;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                scratch_n   = {scratch_adj[14:0], shift_bin[15]};
                shift_bin_n = {shift_bin[14:0], 1'b0};
                bit_cnt_n   = bit_cnt + 4'd1;
                if (bit_cnt == 4'd15)
                    state_n = LOAD;
            end
            LOAD: begin
                bcd_n   = scratch;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_bin <= 16'h0000;
            scratch   <= 16'h0000;
            bit_cnt   <= 4'd0;
            last_bin  <= 14'd0;
            bcd       <= 16'h0000;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_bin <= shift_bin_n;
            scratch   <= scratch_n;
            bit_cnt   <= bit_cnt_n;
            last_bin  <= last_bin_n;
            bcd       <= bcd_n;
            busy      <= busy_n;
        end
    end

    // Digit k>0 is blank when it and every more significant digit are zero.
    always_comb begin
        digit_nib   = bcd[{digit_idx, 2'b00} +: 4];
        digit_blank = 1'b0;
        case (digit_idx)
            2'd1:    digit_blank = (bcd[15:4] == 12'h000);
            2'd2:    digit_blank = (bcd[15:8] == 8'h00);
            2'd3:    digit_blank = (bcd[15:12] == 4'h0);
            default: digit_blank = 1'b0;
        endcase
        seg_n = (BLANK_LEAD && digit_blank) ? 7'h7F : seg_decode(digit_nib);
    end

    // The display stays dark until the first refresh wrap sets lit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            lit         <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'h7F;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
                lit         <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
            if (lit) begin
                an  <= ~(4'b0001 << digit_idx);
                seg <= seg_n;
            end else begin
                an  <= 4'b1111;
                seg <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_score_seg_display.sv
// tb/tb_score_seg_display.sv - self-checking bench for score_seg_display with an arithmetic reference model
module tb_score_seg_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] score;
    logic [3:0]  an1, an0;
    logic [6:0]  seg1, seg0;
    logic        dp1, dp0;
    logic [15:0] bcd1, bcd0;
    logic        busy1, busy0;

    always #5 clk = ~clk;

    score_seg_display #(.REFRESH_DIV(4), .BLANK_LEAD(1'b1)) u_b1 (
        .clk(clk), .rst(rst), .score(score), .an(an1), .seg(seg1),
        .dp(dp1), .bcd(bcd1), .busy(busy1)
    );

    score_seg_display #(.REFRESH_DIV(4), .BLANK_LEAD(1'b0)) u_b0 (
        .clk(clk), .rst(rst), .score(score), .an(an0), .seg(seg0),
        .dp(dp0), .bcd(bcd0), .busy(busy0)
    );

    typedef struct {
        logic [15:0] stim;
        logic [15:0] exp_bcd;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   ecount;
    int   model_val;
    vec_t vecs[10];
    logic [6:0] pat[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int   pw[4] = '{1, 10, 100, 1000};

    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    function automatic int sat(input int x);
        return (x > 9999) ? 9999 : x;
    endfunction

    function automatic logic [15:0] to_bcd(input int x);
        int v;
        v = sat(x);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_an", an1, 4'b1111);
        chk("rst_seg", seg1, 7'h7F);
        chk("rst_dp", dp1, 1'b1);
        chk("rst_bcd", bcd1, 16'h0000);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_an_b0", an0, 4'b1111);
        chk("rst_bcd_b0", bcd0, 16'h0000);
    endtask

    // Expected display from edges since reset: wrap every 4 edges, outputs lag one edge.
    task automatic check_disp(input int v);
        int w, k, d;
        logic [3:0] e_an;
        logic [6:0] e_seg1, e_seg0;
        e_an = 4'b1111; e_seg1 = 7'h7F; e_seg0 = 7'h7F;
        if (ecount > 0) begin
            w = (ecount - 1) / 4;
            if (w > 0) begin
                k      = w % 4;
                d      = (v / pw[k]) % 10;
                e_an   = ~(4'b0001 << k);
                e_seg0 = pat[d];
                e_seg1 = (k > 0 && v < pw[k]) ? 7'h7F : pat[d];
            end
        end
        chk("an_b1", an1, e_an);
        chk("an_b0", an0, e_an);
        chk("seg_b1", seg1, e_seg1);
        chk("seg_b0", seg0, e_seg0);
        chk("dp", dp1, 1'b1);
        chk("busy_idle", busy1, 1'b0);
        chk("bcd_idle", bcd1, to_bcd(v));
    endtask

    task automatic disp_run(input int n);
        repeat (n) begin
            @(negedge clk);
            check_disp(model_val);
        end
    endtask

    task automatic run_conv(input logic [15:0] s, input logic [15:0] e);
        int len;
        logic [15:0] old_exp, seen;
        old_exp = to_bcd(model_val);
        seen    = old_exp;
        score   = s;
        @(negedge clk);
        len = 0;
        while (busy1 && len < 40) begin
            seen = bcd1;
            len++;
            @(negedge clk);
        end
        chk("busy_len", len, 17);
        chk("bcd_hold", seen, old_exp);
        chk("bcd", bcd1, e);
        chk("bcd_b0", bcd0, e);
        chk("busy_drop", busy1, 1'b0);
        model_val = sat(int'(s));
    endtask

    initial begin
        int n, len;
        logic [15:0] r;

        vecs[0] = '{16'd1234,  16'h1234};
        vecs[1] = '{16'hFFFF,  16'h9999};
        vecs[2] = '{16'd7,     16'h0007};
        vecs[3] = '{16'd10000, 16'h9999};
        vecs[4] = '{16'd9998,  16'h9998};
        vecs[5] = '{16'd1,     16'h0001};
        vecs[6] = '{16'd10,    16'h0010};
        vecs[7] = '{16'd100,   16'h0100};
        vecs[8] = '{16'd1000,  16'h1000};
        vecs[9] = '{16'd5009,  16'h5009};

        rst = 1'b1;
        score = 16'd0;
        model_val = 0;
        #12;
        check_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        disp_run(24);

        for (int i = 0; i < 10; i++) begin
            run_conv(vecs[i].stim, vecs[i].exp_bcd);
            disp_run(16);
        end

        // A change while busy must be converted once the first conversion lands.
        score = 16'd5;
        @(negedge clk);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        score = 16'd6;
        while (busy1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first", bcd1, 16'h0005);
        @(negedge clk);
        len = 0;
        while (busy1 && len < 40) begin
            len++;
            @(negedge clk);
        end
        chk("b2b_len", len, 17);
        chk("b2b_second", bcd1, 16'h0006);
        model_val = 6;
        disp_run(16);

        // Reset during SHIFT aborts at once; 42 converts after release.
        score = 16'd1234;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy1, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset();
        @(negedge clk);
        score = 16'd42;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (bcd1 !== 16'h0042 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("rst_bcd42", bcd1, 16'h0042);
        chk("rst_lat", (n <= 18), 1'b1);
        model_val = 42;
        disp_run(16);

        // After reset a score of zero must not start a conversion.
        score = 16'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_val = 0;
        disp_run(8);

        for (int i = 0; i < 20; i++) begin
            r = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 20));
            if (sat(int'(r)) == model_val) begin
                score = r;
                repeat (2) @(negedge clk);
                chk("rnd_nochange", busy1, 1'b0);
            end else begin
                run_conv(r, to_bcd(int'(r)));
            end
            disp_run(8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
